// File: rtl/npc_datapath.sv
// npc single-cycle RV32 execute datapath: decoder, 2R/1W register file and ALU.
// Optional macro RV32E_EN restricts the register file to x0..x15 (RV32E).
module npc_datapath #(
    parameter logic [31:0] REG_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [31:0] alu_result,
    output logic        reg_wen,
    output logic        illegal,
    output logic        ebreak,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

`ifdef RV32E_EN
    localparam int NREGS = 16;
`else
    localparam int NREGS = 32;
`endif

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_LUI
    } alu_op_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_u  = {inst[31:12], 12'b0};

    // ------------------------------------------------------------------
    // Decoder
    // ------------------------------------------------------------------
    alu_op_t alu_op;
    logic    legal_fmt;
    logic    use_imm;
    logic    uses_rs1;
    logic    uses_rs2;
    logic    uses_rd;
    logic    reg_idx_bad;
    logic    exec_ok;
    logic    ebreak_dec;

    // Maps funct3 to the shared ALU op for OP-IMM and OP (funct7 = 0)
    function automatic logic f3_legal(input logic [2:0] f3, output alu_op_t op);
        f3_legal = 1'b1;
        op       = ALU_ADD;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: f3_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_op    = ALU_ADD;
        legal_fmt = 1'b0;
        use_imm   = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        uses_rd   = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                legal_fmt = f3_legal(funct3, alu_op);
                use_imm   = 1'b1;
                uses_rs1  = 1'b1;
                uses_rd   = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                uses_rd  = 1'b1;
                if (funct7 == 7'b0000000) begin
                    legal_fmt = f3_legal(funct3, alu_op);
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal_fmt = 1'b1;
                    alu_op    = ALU_SUB;
                end
            end
            OPC_LUI: begin
                legal_fmt = 1'b1;
                alu_op    = ALU_LUI;
                uses_rd   = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RV32E_EN
    // Indices x16..x31 do not exist; only fields the instruction really uses count
    assign reg_idx_bad = (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4]);
`else
    assign reg_idx_bad = 1'b0 & (uses_rs1 | uses_rs2 | uses_rd);
`endif

    assign ebreak_dec = (inst == INST_EBREAK);
    assign exec_ok    = legal_fmt && !reg_idx_bad;
    assign reg_wen    = exec_ok;
    assign illegal    = !exec_ok && !ebreak_dec;
    assign ebreak     = ebreak_dec;

    // ------------------------------------------------------------------
    // Register file: x0 and unimplemented indices read as zero
    // ------------------------------------------------------------------
    logic [31:0] rf_view [0:31];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rf
            if (gi > 0 && gi < NREGS) begin : g_reg
                logic [31:0] q_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= REG_RESET;
                    end else if (reg_wen && rd == 5'(gi)) begin
                        q_reg <= alu_result;
                    end
                end
                assign rf_view[gi] = q_reg;
            end else begin : g_zero
                assign rf_view[gi] = 32'h0;
            end
        end
    endgenerate

    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    // Reads are combinational with no bypass, so a same-cycle write is not visible
    assign rs1_data = rf_view[rs1];
    assign rs2_data = rf_view[rs2];
    assign dbg_data = rf_view[dbg_addr];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [31:0] op_b;
    logic [31:0] alu_raw;

    assign op_b = use_imm ? imm_i : rs2_data;

    always_comb begin
        alu_raw = 32'h0;
        case (alu_op)
            ALU_ADD:  alu_raw = rs1_data + op_b;
            ALU_SUB:  alu_raw = rs1_data - op_b;
            ALU_SLT:  alu_raw = {31'b0, ($signed(rs1_data) < $signed(op_b))};
            ALU_SLTU: alu_raw = {31'b0, (rs1_data < op_b)};
            ALU_XOR:  alu_raw = rs1_data ^ op_b;
            ALU_OR:   alu_raw = rs1_data | op_b;
            ALU_AND:  alu_raw = rs1_data & op_b;
            ALU_LUI:  alu_raw = imm_u;
            default:  alu_raw = 32'h0;
        endcase
    end

    // Anything not executed (illegal or EBREAK) drives a zero result
    assign alu_result = exec_ok ? alu_raw : 32'h0;

endmodule

// File: tb/tb_npc_datapath.sv
// Self-checking bench for npc_datapath: reset sequence, a vector table with a
// scoreboard queue, and an asynchronous mid-cycle reset check.
module tb_npc_datapath;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] alu_result;
    logic        reg_wen;
    logic        illegal;
    logic        ebreak;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    npc_datapath dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst       (inst),
        .alu_result (alu_result),
        .reg_wen    (reg_wen),
        .illegal    (illegal),
        .ebreak     (ebreak),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    typedef struct {
        logic [31:0] inst;
        logic        chk_alu;
        logic [31:0] alu;
        logic        wen;
        logic        ill;
        logic        ebk;
        logic [4:0]  ra;
        logic [31:0] rv;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] i, input logic ca, input logic [31:0] a,
                       input logic w, input logic il, input logic eb,
                       input logic [4:0] ra, input logic [31:0] rv);
        vec_t v;
        v.inst = i; v.chk_alu = ca; v.alu = a; v.wen = w;
        v.ill = il; v.ebk = eb; v.ra = ra; v.rv = rv;
        vecs.push_back(v);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        @(negedge clk);
        inst     = v.inst;
        dbg_addr = v.ra;
        sb_q.push_back(v);
        #2;
        e = sb_q.pop_front();
        if (e.chk_alu) check($sformatf("v%0d alu_result", idx), alu_result, e.alu);
        check($sformatf("v%0d reg_wen", idx), {31'b0, reg_wen}, {31'b0, e.wen});
        check($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, e.ill});
        check($sformatf("v%0d ebreak", idx), {31'b0, ebreak}, {31'b0, e.ebk});
        @(posedge clk);
        #1;
        check($sformatf("v%0d x%0d", idx, e.ra), dbg_data, e.rv);
        $display("vec %0d inst=%08h alu=%08h wen=%0b ill=%0b ebk=%0b x%0d=%08h",
                 idx, e.inst, alu_result, reg_wen, illegal, ebreak, e.ra, dbg_data);
    endtask

    initial begin
        rst_n    = 1'b0;
        inst     = 32'h0;
        dbg_addr = 5'd0;

        // Register file reads all-zero while held in reset
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            dbg_addr = 5'(a);
            #1;
            check($sformatf("reset x%0d", a), dbg_data, 32'h0);
        end

        // Decode is live during reset but the write is blocked
        @(negedge clk);
        inst     = 32'h0050_0093;
        dbg_addr = 5'd1;
        #1;
        check("reset alu_result", alu_result, 32'h5);
        check("reset reg_wen", {31'b0, reg_wen}, 32'h1);
        @(posedge clk);
        #1;
        check("reset x1 blocked", dbg_data, 32'h0);

        // Release mid-cycle: first write lands on the next rising edge
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("release x1 before edge", dbg_data, 32'h0);
        @(posedge clk);
        #1;
        check("release x1 after edge", dbg_data, 32'h5);

        add(32'h0050_0093, 1, 32'h0000_0005, 1, 0, 0, 5'd1, 32'h0000_0005);
        add(32'hFFF0_8113, 1, 32'h0000_0004, 1, 0, 0, 5'd2, 32'h0000_0004);
        add(enc_i(12'h007, 5'd0, 3'd0, 5'd0), 1, 32'h0000_0007, 1, 0, 0, 5'd0, 32'h0);
        add(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd3), 1, 32'h0, 1, 0, 0, 5'd3, 32'h0);
        add(enc_u(20'h80000, 5'd1), 1, 32'h8000_0000, 1, 0, 0, 5'd1, 32'h8000_0000);
        add(enc_i(12'h001, 5'd0, 3'd0, 5'd2), 1, 32'h0000_0001, 1, 0, 0, 5'd2, 32'h0000_0001);
        add(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 1, 32'h7FFF_FFFF, 1, 0, 0, 5'd4, 32'h7FFF_FFFF);
        add(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd5), 1, 32'h0000_0001, 1, 0, 0, 5'd5, 32'h0000_0001);
        add(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd6), 1, 32'h0, 1, 0, 0, 5'd6, 32'h0);
        add(enc_u(20'h12345, 5'd7), 1, 32'h1234_5000, 1, 0, 0, 5'd7, 32'h1234_5000);
        add(32'h0000_0000, 1, 32'h0, 0, 1, 0, 5'd7, 32'h1234_5000);
        add(32'h0010_0073, 0, 32'h0, 0, 0, 1, 5'd1, 32'h8000_0000);
        add(enc_r(7'h00, 5'd2, 5'd4, 3'd0, 5'd8), 1, 32'h8000_0000, 1, 0, 0, 5'd8, 32'h8000_0000);
        add(enc_r(7'h00, 5'd4, 5'd1, 3'd4, 5'd9), 1, 32'hFFFF_FFFF, 1, 0, 0, 5'd9, 32'hFFFF_FFFF);
        add(enc_i(12'h0F0, 5'd7, 3'd6, 5'd10), 1, 32'h1234_50F0, 1, 0, 0, 5'd10, 32'h1234_50F0);
        add(enc_i(12'hFF0, 5'd9, 3'd7, 5'd11), 1, 32'hFFFF_FFF0, 1, 0, 0, 5'd11, 32'hFFFF_FFF0);
        add(enc_i(12'hFFF, 5'd7, 3'd4, 5'd12), 1, 32'hEDCB_AFFF, 1, 0, 0, 5'd12, 32'hEDCB_AFFF);
        add(enc_i(12'hFFF, 5'd1, 3'd2, 5'd13), 1, 32'h0000_0001, 1, 0, 0, 5'd13, 32'h0000_0001);
        add(enc_i(12'hFFF, 5'd2, 3'd3, 5'd14), 1, 32'h0000_0001, 1, 0, 0, 5'd14, 32'h0000_0001);
        add(enc_i(12'h000, 5'd9, 3'd2, 5'd15), 1, 32'h0000_0001, 1, 0, 0, 5'd15, 32'h0000_0001);
        add(enc_r(7'h00, 5'd7, 5'd9, 3'd7, 5'd3), 1, 32'h1234_5000, 1, 0, 0, 5'd3, 32'h1234_5000);
        add(enc_r(7'h00, 5'd10, 5'd5, 3'd6, 5'd5), 1, 32'h1234_50F1, 1, 0, 0, 5'd5, 32'h1234_50F1);
        add(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd6), 1, 32'h8000_0001, 1, 0, 0, 5'd6, 32'h8000_0001);
        add(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd4), 1, 32'h0, 1, 0, 0, 5'd4, 32'h0);
        add(enc_r(7'h00, 5'd1, 5'd2, 3'd3, 5'd8), 1, 32'h0000_0001, 1, 0, 0, 5'd8, 32'h0000_0001);
        add(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd1), 1, 32'h0, 0, 1, 0, 5'd1, 32'h8000_0000);
        add(enc_i(12'h001, 5'd1, 3'd1, 5'd1), 1, 32'h0, 0, 1, 0, 5'd1, 32'h8000_0000);
        add(enc_r(7'h20, 5'd2, 5'd1, 3'd4, 5'd1), 1, 32'h0, 0, 1, 0, 5'd1, 32'h8000_0000);
`ifdef RV32E_EN
        add(enc_i(12'hFFB, 5'd0, 3'd0, 5'd31), 1, 32'h0, 0, 1, 0, 5'd31, 32'h0);
        add(enc_i(12'h001, 5'd0, 3'd0, 5'd16), 1, 32'h0, 0, 1, 0, 5'd16, 32'h0);
        add(enc_r(7'h00, 5'd0, 5'd16, 3'd0, 5'd3), 1, 32'h0, 0, 1, 0, 5'd3, 32'h1234_5000);
`else
        add(enc_i(12'hFFB, 5'd0, 3'd0, 5'd31), 1, 32'hFFFF_FFFB, 1, 0, 0, 5'd31, 32'hFFFF_FFFB);
        add(enc_i(12'h001, 5'd0, 3'd0, 5'd16), 1, 32'h0000_0001, 1, 0, 0, 5'd16, 32'h0000_0001);
        add(enc_r(7'h00, 5'd0, 5'd16, 3'd0, 5'd3), 1, 32'h0000_0001, 1, 0, 0, 5'd3, 32'h0000_0001);
`endif
        add(enc_i(12'h001, 5'd1, 3'd0, 5'd1), 1, 32'h8000_0001, 1, 0, 0, 5'd1, 32'h8000_0001);
        add(enc_i(12'h001, 5'd1, 3'd0, 5'd1), 1, 32'h8000_0002, 1, 0, 0, 5'd1, 32'h8000_0002);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i);
        end
        check("scoreboard drained", 32'(sb_q.size()), 32'h0);

        // Asynchronous reset clears registers without waiting for a clock edge
        @(negedge clk);
        inst     = 32'h0000_0000;
        dbg_addr = 5'd7;
        #1;
        check("pre-reset x7", dbg_data, 32'h1234_5000);
        rst_n = 1'b0;
        #1;
        check("async reset x7", dbg_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
